// File: rtl/i2c_controller.sv
// I2C write-only initiator: START, addr+W, register byte, data byte, STOP, with per-transaction NACK report.
// Optional target clock stretching is enabled by defining CLOCK_STRETCH_EN.
module i2c_controller #(
  parameter int unsigned QDIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [6:0] dev_addr_i,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] data_i,
  output logic       done_o,
  output logic       nack_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_ACK, S_STOP} state_e;

  state_e      state_q, state_d;
  logic [7:0]  qcnt_q;
  logic [1:0]  qph_q;
  logic [2:0]  bit_q;
  logic [1:0]  byte_q;
  logic [7:0]  sh_q, reg_q, dat_q;
  logic        nack_q, done_q, nack_out_q;
  logic        stall, tick, last_q;

  // Quarters in which SCL is released and the target may hold it low
`ifdef CLOCK_STRETCH_EN
  logic scl_rel_win;
  assign scl_rel_win = (((state_q == S_BITS) || (state_q == S_ACK)) && (qph_q == 2'd2)) ||
                       ((state_q == S_STOP) && (qph_q == 2'd1));
  assign stall = scl_rel_win && !scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign stall = 1'b0;
`endif

  assign tick   = (qcnt_q == 8'(QDIV - 1)) && !stall;
  assign last_q = tick && (qph_q == 2'd3);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid_i) state_d = S_START;
      S_START: if (tick && qph_q == 2'd2) state_d = S_BITS;
      S_BITS:  if (last_q && bit_q == 3'd7) state_d = S_ACK;
      S_ACK:   if (last_q) state_d = (nack_q || byte_q == 2'd2) ? S_STOP : S_BITS;
      S_STOP:  if (last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    scl_oe_o = 1'b0;
    sda_oe_o = 1'b0;
    case (state_q)
      S_START: begin
        scl_oe_o = (qph_q == 2'd2);
        sda_oe_o = (qph_q != 2'd0);
      end
      S_BITS: begin
        scl_oe_o = (qph_q < 2'd2);
        sda_oe_o = ~sh_q[7];
      end
      S_ACK:  scl_oe_o = (qph_q < 2'd2);
      S_STOP: begin
        scl_oe_o = (qph_q == 2'd0);
        sda_oe_o = (qph_q < 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      qcnt_q  <= '0;
      qph_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE || tick) qcnt_q <= '0;
      else if (!stall)               qcnt_q <= qcnt_q + 8'd1;
      if (state_d != state_q) qph_q <= '0;
      else if (tick)          qph_q <= qph_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_q      <= '0;
      byte_q     <= '0;
      sh_q       <= '0;
      reg_q      <= '0;
      dat_q      <= '0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cmd_valid_i) begin
          sh_q       <= {dev_addr_i, 1'b0};
          reg_q      <= reg_addr_i;
          dat_q      <= data_i;
          bit_q      <= '0;
          byte_q     <= '0;
          nack_q     <= 1'b0;
          nack_out_q <= 1'b0;
        end
        S_BITS: if (last_q) begin
          sh_q  <= {sh_q[6:0], 1'b0};
          bit_q <= bit_q + 3'd1;
        end
        S_ACK: begin
          if (tick && qph_q == 2'd2 && sda_i) nack_q <= 1'b1;
          if (last_q && !nack_q && byte_q != 2'd2) begin
            byte_q <= byte_q + 2'd1;
            sh_q   <= (byte_q == 2'd0) ? reg_q : dat_q;
          end
        end
        S_STOP: if (last_q) begin
          done_q     <= 1'b1;
          nack_out_q <= nack_q;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign done_o      = done_q;
  assign nack_o      = nack_out_q;

endmodule
